// File: rtl/load_pkg.sv
// Shared definitions for the load unit: FSM states, access-size codes, opcode and
// instruction field positions.
package load_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWb
  } load_state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] OPC_LOAD = 4'hB;

  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned SIZE_MSB = 11;
  localparam int unsigned SIZE_LSB = 10;
  localparam int unsigned RD_MSB   = 9;
  localparam int unsigned RD_LSB   = 5;
  localparam int unsigned RS_MSB   = 4;
  localparam int unsigned RS_LSB   = 0;

  // True when the access cannot be issued: wrong opcode, reserved size or misaligned address.
  function automatic logic load_illegal(input logic [3:0] opc, input logic [3:0] opc_load,
                                        input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = (opc != opc_load) || (size == 2'b11);
    if (size == SZ_H && addr_lo[0]) bad = 1'b1;
    if (size == SZ_W && addr_lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational read-data aligner: selects the byte/half lane from the returned word
// and sign-extends it to the register width.
module load_align
  import load_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      SZ_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      SZ_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: decodes a LOAD, issues one data-memory read, aligns the result and writes it back.
// Optional LOAD_TIMEOUT_EN bounds the wait for mem_ready to TIMEOUT_CYCLES cycles.
module load_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned REG_AW         = 5,
  parameter logic [3:0]  OPC_LOAD       = load_pkg::OPC_LOAD,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] rs_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);
  import load_pkg::*;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [REG_AW-1:0] rd_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q, err_d;
  logic              latch, capture, tmo_hit;
  logic              illegal;
  logic [DATA_W-1:0] aligned;
  logic              unused_rs;

  // rs is resolved upstream; only its value arrives on rs_data.
  assign unused_rs = ^instruction[RS_MSB:RS_LSB];

  assign illegal = load_illegal(instruction[OPC_MSB:OPC_LSB], OPC_LOAD,
                                instruction[SIZE_MSB:SIZE_LSB], rs_data[1:0]);

  load_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size   (size_q),
    .addr_lo(addr_q[1:0]),
    .rdata  (mem_rdata),
    .data   (aligned)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (latch) begin
      cnt_q <= '0;
    end else if (state_q == StReq) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    latch   = 1'b0;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            latch   = 1'b1;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_ready) begin
          capture = 1'b1;
          state_d = StWb;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      addr_q  <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (latch) begin
        addr_q <= rs_data[ADDR_W-1:0];
        rd_q   <= instruction[RD_MSB:RD_LSB];
        size_q <= instruction[SIZE_MSB:SIZE_LSB];
      end
      if (capture) begin
        data_q <= aligned;
      end
    end
  end

  assign busy     = (state_q != StIdle);
  assign mem_req  = (state_q == StReq);
  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign done     = (state_q == StWb);
  // Register 0 is hard-wired, so its writeback is dropped but the load still completes.
  assign wb_en    = (state_q == StWb) && (rd_q != '0);
  assign wb_addr  = rd_q;
  assign wb_data  = data_q;
  assign err      = err_q;

endmodule
